fp_mult: RTL and testbench
==========================

Name: fp_mult

Overview:
- IEEE-754 single-precision (binary32) multiplier. Takes two 32-bit operands and produces their rounded product.
- Combinational datapath: unpack, multiply, normalise, round, pack. The result is captured in one output register stage.
- Used as the multiply unit of the FPU. Sits beside the adder, and the FPU top-level issues operands to it.

Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand_a/operand_b valid this cycle
- operand_a  input  32  binary32 operand A
- operand_b  input  32  binary32 operand B
- result  output  32  registered binary32 product
- out_valid  output  1  result holds product of operands presented with in_valid one cycle earlier

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: result=32'h00000000 and out_valid=0 immediately on rst assertion, independent of clk. Both stay there until the first rising edge after rst deasserts.
- Latency is exactly 1 cycle; throughput is one operation per cycle; there is no backpressure.
  - Each rising edge: out_valid <= in_valid.
  - When in_valid=1: result <= f(operand_a, operand_b).
  - When in_valid=0: result holds its value.
- Unpack fields: sign s (bit 31), exponent e (bits 30:23), fraction f (bits 22:0).
- Denormal inputs (e=0, f!=0) are flushed to signed zero before use.
- Special cases, checked in priority order:
  - Either operand is NaN (e=255, f!=0) -> 32'h7FC00000.
  - Infinity times zero -> 32'h7FC00000.
  - Either operand is infinity -> {sa^sb, 8'hFF, 23'h0}.
  - Either operand is zero -> {sa^sb, 31'h0}, e.g. +1.5 * +0 = 32'h00000000.
- Normal path:
  - Sign = sa^sb.
  - Mantissas ma={1,fa} and mb={1,fb}, 24 bits each. Product p = ma*mb is 48 bits and lies in [2^46, 2^48).
  - Exponent: exp = ea+eb-127, computed in 10-bit signed arithmetic.
  - Normalise: if p[47]=1, exp+=1 and take mantissa p[46:24], guard p[23], sticky |p[22:0]. Otherwise take mantissa p[45:23], guard p[22], sticky |p[21:0].
  - Round to nearest, ties to even: increment when guard & (sticky | mantissa lsb).
  - If the increment carries out of 23 bits: mantissa=0, exp+=1.
- Overflow: final exp >= 255 -> {sign, 8'hFF, 23'h0}.
- Underflow: final exp <= 0 -> {sign, 31'h0}. No denormal outputs are produced.
- Exact results such as 1.0*x must reproduce x bit-exactly.
- The multiply is commutative; swapping operands gives an identical result.

Test Plan:
- Reset: assert rst mid-run with in_valid=1 -> result=0 and out_valid=0 with no clock edge; first edge after release with in_valid=0 -> out_valid stays 0.
- Basic products, each with in_valid=1 and checked one cycle later:
  - 3F800000*3F800000 -> 3F800000
  - 3F800000*40000000 -> 40000000
  - 3F800000*3FFFFFFF -> 3FFFFFFF
  - 3FC00000*3FC00000 -> 40100000
- Zero handling:
  - 3FC00000*00000000 -> 00000000
  - 00000000*3FC00000 -> 00000000
  - BF800000*00000000 -> 80000000
  - 3FC00000*00000001 (denormal) -> 00000000
- Specials:
  - 7F800000*00000000 -> 7FC00000
  - 7FC00001*3F800000 -> 7FC00000
  - FF800000*40000000 -> FF800000
  - 7F7FFFFF*40000000 -> 7F800000 (overflow)
  - 00800000*00800000 -> 00000000 (underflow)
- Rounding:
  - 3F800001*3F800001 -> 3F800002 (round-to-nearest)
  - 3FFFFFFF*3FFFFFFF -> 407FFFFE
- Streaming: back-to-back in_valid for 4 cycles with distinct operand pairs -> 4 consecutive out_valid cycles in order; a gap in in_valid produces a gap in out_valid and result holds its value.

Source files
------------

// File: rtl/fp_mult.sv
// IEEE-754 binary32 multiplier: combinational unpack/multiply/normalise/round/pack
// followed by a single output register stage (latency 1, one op per cycle).
module fp_mult (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic [31:0] result,
    output logic        out_valid
);

    logic        sign_a, sign_b, sign_p;
    logic [7:0]  exp_a, exp_b;
    logic [22:0] frac_a, frac_b;
    logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [47:0] prod;
    logic [9:0]  exp_sum;
    logic [9:0]  exp_norm;
    logic [9:0]  exp_final;
    logic [22:0] mant;
    logic        guard, sticky, round_up;
    logic [23:0] mant_rnd;
    logic [22:0] mant_final;
    logic [31:0] product;

    assign sign_a = operand_a[31];
    assign sign_b = operand_b[31];
    assign exp_a  = operand_a[30:23];
    assign exp_b  = operand_b[30:23];
    assign frac_a = operand_a[22:0];
    assign frac_b = operand_b[22:0];
    assign sign_p = sign_a ^ sign_b;

    // Denormals have exponent 0, so they fall into the zero class and get flushed.
    assign nan_a  = (exp_a == 8'hFF) && (frac_a != 23'h0);
    assign nan_b  = (exp_b == 8'hFF) && (frac_b != 23'h0);
    assign inf_a  = (exp_a == 8'hFF) && (frac_a == 23'h0);
    assign inf_b  = (exp_b == 8'hFF) && (frac_b == 23'h0);
    assign zero_a = (exp_a == 8'h00);
    assign zero_b = (exp_b == 8'h00);

    assign prod    = {24'h0, 1'b1, frac_a} * {24'h0, 1'b1, frac_b};
    assign exp_sum = {2'b00, exp_a} + {2'b00, exp_b} - 10'd127;

    always_comb begin
        exp_norm   = exp_sum;
        mant       = prod[45:23];
        guard      = prod[22];
        sticky     = |prod[21:0];
        round_up   = 1'b0;
        mant_rnd   = 24'h0;
        mant_final = 23'h0;
        exp_final  = exp_sum;
        product    = 32'h0;

        if (prod[47]) begin
            exp_norm = exp_sum + 10'd1;
            mant     = prod[46:24];
            guard    = prod[23];
            sticky   = |prod[22:0];
        end

        // Round to nearest, ties to even; a carry out of the mantissa bumps the exponent.
        round_up  = guard & (sticky | mant[0]);
        mant_rnd  = {1'b0, mant} + {23'h0, round_up};
        exp_final = exp_norm;
        mant_final = mant_rnd[22:0];
        if (mant_rnd[23]) begin
            mant_final = 23'h0;
            exp_final  = exp_norm + 10'd1;
        end

        if (nan_a || nan_b) begin
            product = 32'h7FC00000;
        end else if ((inf_a && zero_b) || (inf_b && zero_a)) begin
            product = 32'h7FC00000;
        end else if (inf_a || inf_b) begin
            product = {sign_p, 8'hFF, 23'h0};
        end else if (zero_a || zero_b) begin
            product = {sign_p, 31'h0};
        end else if ($signed(exp_final) >= $signed(10'sd255)) begin
            product = {sign_p, 8'hFF, 23'h0};
        end else if ($signed(exp_final) <= $signed(10'sd0)) begin
            product = {sign_p, 31'h0};
        end else begin
            product = {sign_p, exp_final[7:0], mant_final};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result    <= 32'h0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                result <= product;
        end
    end

endmodule

// File: tb/tb_fp_mult.sv
// Directed-vector bench for fp_mult; expected products are hand-computed binary32 values.
module tb_fp_mult;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [31:0] result;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    fp_mult dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result    (result),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one cycle of inputs and returns just after the capturing edge.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic v);
        @(negedge clk);
        in_valid  = v;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(32'h3F800000, 32'h40000000, 1'b1);
        @(negedge clk);
        in_valid  = 1'b1;
        operand_a = 32'h3FC00000;
        operand_b = 32'h3FC00000;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (result !== 32'h0) begin
            $display("[TB] FAIL reset_async_result: got %h want %h", result, 32'h0);
            errors++;
        end
        checks++;
        if (out_valid !== 1'b0) begin
            $display("[TB] FAIL reset_async_valid: got %b want 0", out_valid);
            errors++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            $display("[TB] FAIL reset_release_valid: got %b want 0", out_valid);
            errors++;
        end
        checks++;
        if (result !== 32'h0) begin
            $display("[TB] FAIL reset_release_result: got %h want %h", result, 32'h0);
            errors++;
        end
    endtask

    task automatic test_basic();
        logic [31:0] va [4] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3FC00000};
        logic [31:0] vb [4] = '{32'h3F800000, 32'h40000000, 32'h3FFFFFFF, 32'h3FC00000};
        logic [31:0] ve [4] = '{32'h3F800000, 32'h40000000, 32'h3FFFFFFF, 32'h40100000};
        for (int i = 0; i < 4; i++) begin
            drive(va[i], vb[i], 1'b1);
            checks++;
            if (result !== ve[i] || out_valid !== 1'b1) begin
                $display("[TB] FAIL basic_%0d: got %h/%b want %h/1", i, result, out_valid, ve[i]);
                errors++;
            end
            drive(vb[i], va[i], 1'b1);
            checks++;
            if (result !== ve[i]) begin
                $display("[TB] FAIL basic_swap_%0d: got %h want %h", i, result, ve[i]);
                errors++;
            end
        end
    endtask

    task automatic test_zero();
        logic [31:0] va [4] = '{32'h3FC00000, 32'h00000000, 32'hBF800000, 32'h3FC00000};
        logic [31:0] vb [4] = '{32'h00000000, 32'h3FC00000, 32'h00000000, 32'h00000001};
        logic [31:0] ve [4] = '{32'h00000000, 32'h00000000, 32'h80000000, 32'h00000000};
        for (int i = 0; i < 4; i++) begin
            drive(32'h40400000, 32'h40400000, 1'b1);
            drive(va[i], vb[i], 1'b1);
            checks++;
            if (result !== ve[i]) begin
                $display("[TB] FAIL zero_%0d: got %h want %h", i, result, ve[i]);
                errors++;
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] va [5] = '{32'h7F800000, 32'h7FC00001, 32'hFF800000, 32'h7F7FFFFF, 32'h00800000};
        logic [31:0] vb [5] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h00800000};
        logic [31:0] ve [5] = '{32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'h00000000};
        for (int i = 0; i < 5; i++) begin
            drive(va[i], vb[i], 1'b1);
            checks++;
            if (result !== ve[i]) begin
                $display("[TB] FAIL special_%0d: got %h want %h", i, result, ve[i]);
                errors++;
            end
            drive(vb[i], va[i], 1'b1);
            checks++;
            if (result !== ve[i]) begin
                $display("[TB] FAIL special_swap_%0d: got %h want %h", i, result, ve[i]);
                errors++;
            end
        end
    endtask

    task automatic test_rounding();
        drive(32'h3F800001, 32'h3F800001, 1'b1);
        checks++;
        if (result !== 32'h3F800002) begin
            $display("[TB] FAIL round_nearest: got %h want %h", result, 32'h3F800002);
            errors++;
        end
        drive(32'h3FFFFFFF, 32'h3FFFFFFF, 1'b1);
        checks++;
        if (result !== 32'h407FFFFE) begin
            $display("[TB] FAIL round_max_mant: got %h want %h", result, 32'h407FFFFE);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [4] = '{32'h40000000, 32'h40400000, 32'hC0000000, 32'h3F000000};
        logic [31:0] vb [4] = '{32'h40000000, 32'h40000000, 32'h3F000000, 32'h3F000000};
        logic [31:0] ve [4] = '{32'h40800000, 32'h40C00000, 32'hBF800000, 32'h3E800000};
        for (int i = 0; i < 4; i++) begin
            drive(va[i], vb[i], 1'b1);
            checks++;
            if (result !== ve[i] || out_valid !== 1'b1) begin
                $display("[TB] FAIL stream_%0d: got %h/%b want %h/1", i, result, out_valid, ve[i]);
                errors++;
            end
        end
        drive(32'h40400000, 32'h40400000, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h3E800000) begin
            $display("[TB] FAIL stream_gap: got %h/%b want %h/0", result, out_valid, 32'h3E800000);
            errors++;
        end
        drive(32'h40400000, 32'h40400000, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'h41100000) begin
            $display("[TB] FAIL stream_resume: got %h/%b want %h/1", result, out_valid, 32'h41100000);
            errors++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        operand_a = 32'h0;
        operand_b = 32'h0;
        #1;
        checks++;
        if (result !== 32'h0 || out_valid !== 1'b0) begin
            $display("[TB] FAIL power_on_reset: got %h/%b want 00000000/0", result, out_valid);
            errors++;
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic();
        test_zero();
        test_specials();
        test_rounding();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
